// File: rtl/display_pkg.sv
// Shared display-pipeline definitions: colour widths, sequencer state encoding
// and the end-to-end pixel latency derived from the RAM read latency.
package display_pkg;

  localparam int COLOUR_W = 4;
  localparam int PIX_W    = 3 * COLOUR_W;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_state_t;

  // Input register stage + RAM latency + colour register stage.
  function automatic int pipe_latency(input int ram_lat);
    return ram_lat + 2;
  endfunction

endpackage

// File: rtl/pipe_delay.sv
// Reset-valued shift register of WIDTH bits and DEPTH stages, used to keep
// sync/enable/region flags aligned with the RAM data path.
module pipe_delay #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] taps [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= RST_VAL;
    end else begin
      taps[0] <= d;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign q = taps[DEPTH-1];

endmodule

// File: rtl/framebuffer_reader.sv
// Scales timing-generator coordinates onto a small framebuffer, issues RAM reads
// and delivers blanked 4:4:4 colour with sync/enable aligned to the data.
//
// state | meaning
// IDLE  | after reset; no reads, output shows background/blank until a frame start
// RUN   | frame start seen; reads issued for pixels inside the framebuffer region
module framebuffer_reader
  import display_pkg::*;
#(
  parameter int             FB_W      = 160,
  parameter int             FB_H      = 120,
  parameter int             SCALE_X   = 4,
  parameter int             SCALE_Y   = 4,
  parameter int             ADDR_W    = 15,
  parameter int             RAM_LAT   = 1,
  parameter logic [PIX_W-1:0] BG_COLOUR = 12'h000,
  parameter logic           H_POL     = 1'b0,
  parameter logic           V_POL     = 1'b0
) (
  input  logic                i_pixclk,
  input  logic                i_rst,
  input  logic signed [15:0]  i_x,
  input  logic signed [15:0]  i_y,
  input  logic                i_de,
  input  logic                i_hs,
  input  logic                i_vs,
  input  logic                i_frame,
  output logic [ADDR_W-1:0]   o_addr,
  output logic                o_rd,
  input  logic [PIX_W-1:0]    i_data,
  output logic                o_hs,
  output logic                o_vs,
  output logic                o_de,
  output logic [COLOUR_W-1:0] o_red,
  output logic [COLOUR_W-1:0] o_green,
  output logic [COLOUR_W-1:0] o_blue
);

  localparam int LAT      = pipe_latency(RAM_LAT);
  localparam int REGION_W = FB_W * SCALE_X;
  localparam int REGION_H = FB_H * SCALE_Y;
  localparam int PXW      = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
  localparam int LNW      = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;

  localparam logic [PXW-1:0]    PX_LAST  = PXW'(SCALE_X - 1);
  localparam logic [LNW-1:0]    LN_LAST  = LNW'(SCALE_Y - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(FB_W * FB_H - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_W);

  fsm_state_t        state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] line_base;
  logic [PXW-1:0]    px_rep;
  logic [LNW-1:0]    ln_rep;
  logic              de_q;

  int   x_pos;
  int   y_pos;
  logic x_in;
  logic y_in;
  logic rd_now;
  logic line_end;

  assign x_pos    = int'(i_x);
  assign y_pos    = int'(i_y);
  assign x_in     = (x_pos >= 0) && (x_pos < REGION_W);
  assign y_in     = (y_pos >= 0) && (y_pos < REGION_H);
  assign rd_now   = (state == RUN) && i_de && x_in && y_in;
  assign line_end = de_q && !i_de;

  always_ff @(posedge i_pixclk) begin
    if (i_rst) begin
      state     <= IDLE;
      addr      <= '0;
      line_base <= '0;
      px_rep    <= '0;
      ln_rep    <= '0;
      de_q      <= 1'b0;
      o_addr    <= '0;
      o_rd      <= 1'b0;
    end else begin
      de_q <= i_de;
      o_rd <= rd_now;
      if (rd_now) o_addr <= addr;

      case (state)
        IDLE:    if (i_frame) state <= RUN;
        RUN:     state <= RUN;
        default: state <= IDLE;
      endcase

      // Frame start wins over every other counter update.
      if (i_frame) begin
        addr      <= '0;
        line_base <= '0;
        px_rep    <= '0;
        ln_rep    <= '0;
      end else if (state == RUN) begin
        if (rd_now) begin
          if (px_rep == PX_LAST) begin
            px_rep <= '0;
            addr   <= addr + ADDR_W'(1);
          end else begin
            px_rep <= px_rep + PXW'(1);
          end
        end else if (line_end && y_in) begin
          px_rep <= '0;
          if (ln_rep == LN_LAST) begin
            ln_rep    <= '0;
            line_base <= line_base + ROW_STEP;
            addr      <= line_base + ROW_STEP;
          end else begin
            ln_rep <= ln_rep + LNW'(1);
            addr   <= line_base;
          end
        end
      end
    end
  end

  logic [2:0] sync_q;

  pipe_delay #(
    .WIDTH   (3),
    .DEPTH   (LAT),
    .RST_VAL ({~H_POL, ~V_POL, 1'b0})
  ) u_sync_delay (
    .clk (i_pixclk),
    .rst (i_rst),
    .d   ({i_hs, i_vs, i_de}),
    .q   (sync_q)
  );

  assign {o_hs, o_vs, o_de} = sync_q;

  // Selection flags arrive one stage early so the colour register lands with o_de.
  logic sel_de;
  logic sel_rd;

  pipe_delay #(
    .WIDTH   (2),
    .DEPTH   (LAT - 1),
    .RST_VAL (2'b00)
  ) u_sel_delay (
    .clk (i_pixclk),
    .rst (i_rst),
    .d   ({i_de, rd_now}),
    .q   ({sel_de, sel_rd})
  );

  logic [PIX_W-1:0] colour;

  always_ff @(posedge i_pixclk) begin
    if (i_rst)        colour <= '0;
    else if (!sel_de) colour <= '0;
    else if (sel_rd)  colour <= i_data;
    else              colour <= BG_COLOUR;
  end

  assign {o_red, o_green, o_blue} = colour;

  addr_in_range: assert property (@(posedge i_pixclk) disable iff (i_rst)
    rd_now |-> (addr <= ADDR_MAX));

endmodule
